// File: rtl/ann_stream_loader.sv
// Autonomous load sequencer for the ANN accelerator input FIFO: emits a load_kdtree
// pulse, then node, leaf and query word streams under FIFO backpressure, with cycle accounting.
module ann_stream_loader #(
    parameter int                    DATA_WIDTH = 11,
    parameter int                    LEAF_SIZE  = 8,
    parameter int                    PATCH_SIZE = 5,
    parameter int                    ROW_SIZE   = 26,
    parameter int                    COL_SIZE   = 19,
    parameter int                    NUM_LEAVES = 64,
    parameter int                    CNT_W      = 20,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(11'h500),
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(11'h001)
) (
    input  logic                  io_clk,
    input  logic                  io_rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic                  in_fifo_wfull_n,
    output logic                  load_kdtree,
    output logic                  in_fifo_wenq,
    output logic [DATA_WIDTH-1:0] in_fifo_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            phase,
    output logic [CNT_W-1:0]      kdtree_cycles,
    output logic [CNT_W-1:0]      query_cycles,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [3:0]            fsm_state
);

    localparam int NODE_W  = 2 * (NUM_LEAVES - 1);
    localparam int LEAF_W  = NUM_LEAVES * LEAF_SIZE * (PATCH_SIZE + 1);
    localparam int QUERY_W = ROW_SIZE * COL_SIZE * PATCH_SIZE;
    localparam int MAX_W   = (NODE_W > LEAF_W) ? ((NODE_W > QUERY_W) ? NODE_W : QUERY_W)
                                               : ((LEAF_W > QUERY_W) ? LEAF_W : QUERY_W);
    localparam int IDX_RAW = $clog2(MAX_W + 1);
    // Index must be at least as wide as the data word so ramp data can slice it directly.
    localparam int IDX_W   = (IDX_RAW > DATA_WIDTH) ? IDX_RAW : DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] SEED_EFF =
        (LFSR_SEED == '0) ? DATA_WIDTH'(1) : LFSR_SEED;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PULSE   = 4'd1,
        S_NODES   = 4'd2,
        S_GAP_N   = 4'd3,
        S_LEAVES  = 4'd4,
        S_GAP_L   = 4'd5,
        S_QUERIES = 4'd6,
        S_GAP_Q   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        last_idx;
    logic [DATA_WIDTH-1:0]   lfsr;
    logic [DATA_WIDTH-1:0]   lfsr_next;
    logic                    mode_q;
    logic                    pending;
    logic                    last_word;
    logic                    start_ok;
    logic                    in_kdtree;
    logic                    in_query;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        pending   = 1'b0;
        last_idx  = '0;
        case (state)
            S_NODES:   begin pending = 1'b1; last_idx = IDX_W'(NODE_W - 1);  end
            S_LEAVES:  begin pending = 1'b1; last_idx = IDX_W'(LEAF_W - 1);  end
            S_QUERIES: begin pending = 1'b1; last_idx = IDX_W'(QUERY_W - 1); end
            default:   ;
        endcase
        last_word = (idx == last_idx);
        start_ok  = ((state == S_IDLE) || (state == S_DONE)) && start && !abort;
        in_kdtree = (state == S_PULSE) || (state == S_NODES) || (state == S_GAP_N) ||
                    (state == S_LEAVES) || (state == S_GAP_L);
        in_query  = (state == S_QUERIES) || (state == S_GAP_Q);
        lfsr_next = {lfsr[DATA_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
    end

    // Enqueue is the only input-to-output path; abort kills it in the same cycle.
    always_comb begin
        in_fifo_wenq = pending && in_fifo_wfull_n && !abort;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_next = S_PULSE;
                S_PULSE:   state_next = S_NODES;
                S_NODES:   if (in_fifo_wenq && last_word) state_next = S_GAP_N;
                S_GAP_N:   state_next = S_LEAVES;
                S_LEAVES:  if (in_fifo_wenq && last_word) state_next = S_GAP_L;
                S_GAP_L:   state_next = S_QUERIES;
                S_QUERIES: if (in_fifo_wenq && last_word) state_next = S_GAP_Q;
                S_GAP_Q:   state_next = S_DONE;
                S_DONE:    if (start) state_next = S_PULSE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        load_kdtree   = (state == S_PULSE);
        busy          = (state != S_IDLE) && (state != S_DONE);
        done          = (state == S_DONE);
        fsm_state     = state;
        in_fifo_wdata = '0;
        if (pending) in_fifo_wdata = mode_q ? lfsr : idx[DATA_WIDTH-1:0];
        phase = 2'd0;
        case (state)
            S_PULSE, S_NODES, S_GAP_N: phase = 2'd1;
            S_LEAVES, S_GAP_L:         phase = 2'd2;
            S_QUERIES, S_GAP_Q:        phase = 2'd3;
            default:                   phase = 2'd0;
        endcase
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
            idx    <= '0;
            lfsr   <= SEED_EFF;
        end else begin
            state <= state_next;
            if (start_ok) mode_q <= mode;
            // Outside the data states the generators sit at their per-phase start values.
            if (pending) begin
                if (in_fifo_wenq) begin
                    idx  <= idx + IDX_W'(1);
                    lfsr <= lfsr_next;
                end
            end else begin
                idx  <= '0;
                lfsr <= SEED_EFF;
            end
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            kdtree_cycles <= '0;
            query_cycles  <= '0;
            stall_cycles  <= '0;
        end else if (start_ok) begin
            kdtree_cycles <= '0;
            query_cycles  <= '0;
            stall_cycles  <= '0;
        end else if (!abort) begin
            if (in_kdtree) kdtree_cycles <= sat_inc(kdtree_cycles);
            if (in_query)  query_cycles  <= sat_inc(query_cycles);
            if (pending && !in_fifo_wfull_n) stall_cycles <= sat_inc(stall_cycles);
        end
    end

endmodule

// File: tb/tb_ann_stream_loader.sv
// Directed bench for ann_stream_loader: three geometries share stimulus, one is observed via sel.
module tb_ann_stream_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic mode = 1'b0;
    logic wfull_n = 1'b1;
    int   sel = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic        ld   [3];
    logic        wenq [3];
    logic [10:0] wdat [3];
    logic        bsy  [3];
    logic        dn   [3];
    logic [1:0]  ph   [3];
    logic [19:0] kd   [3];
    logic [19:0] qc   [3];
    logic [19:0] st   [3];
    logic [3:0]  fsm  [3];
    logic [3:0]  wdat_narrow;

    assign wdat[1] = {7'd0, wdat_narrow};

    ann_stream_loader #(
        .DATA_WIDTH(11), .LEAF_SIZE(2), .PATCH_SIZE(5), .ROW_SIZE(2), .COL_SIZE(3), .NUM_LEAVES(4)
    ) u_small (
        .io_clk(clk), .io_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .in_fifo_wfull_n(wfull_n), .load_kdtree(ld[0]), .in_fifo_wenq(wenq[0]),
        .in_fifo_wdata(wdat[0]), .busy(bsy[0]), .done(dn[0]), .phase(ph[0]),
        .kdtree_cycles(kd[0]), .query_cycles(qc[0]), .stall_cycles(st[0]), .fsm_state(fsm[0])
    );

    ann_stream_loader #(
        .DATA_WIDTH(4), .LEAF_SIZE(2), .PATCH_SIZE(5), .ROW_SIZE(2), .COL_SIZE(3), .NUM_LEAVES(4),
        .LFSR_TAPS(4'h9), .LFSR_SEED(4'h1)
    ) u_narrow (
        .io_clk(clk), .io_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .in_fifo_wfull_n(wfull_n), .load_kdtree(ld[1]), .in_fifo_wenq(wenq[1]),
        .in_fifo_wdata(wdat_narrow), .busy(bsy[1]), .done(dn[1]), .phase(ph[1]),
        .kdtree_cycles(kd[1]), .query_cycles(qc[1]), .stall_cycles(st[1]), .fsm_state(fsm[1])
    );

    ann_stream_loader u_full (
        .io_clk(clk), .io_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .in_fifo_wfull_n(wfull_n), .load_kdtree(ld[2]), .in_fifo_wenq(wenq[2]),
        .in_fifo_wdata(wdat[2]), .busy(bsy[2]), .done(dn[2]), .phase(ph[2]),
        .kdtree_cycles(kd[2]), .query_cycles(qc[2]), .stall_cycles(st[2]), .fsm_state(fsm[2])
    );

    logic        ld_s, wenq_s, bsy_s, dn_s;
    logic [10:0] wdat_s;
    logic [1:0]  ph_s;
    logic [19:0] kd_s, qc_s, st_s;
    logic [3:0]  fsm_s;

    always_comb begin
        ld_s = ld[sel]; wenq_s = wenq[sel]; wdat_s = wdat[sel]; bsy_s = bsy[sel];
        dn_s = dn[sel]; ph_s = ph[sel]; kd_s = kd[sel]; qc_s = qc[sel]; st_s = st[sel];
        fsm_s = fsm[sel];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ld"},   32'(ld_s), 0);
        check_val({tag, "_wenq"}, 32'(wenq_s), 0);
        check_val({tag, "_wdat"}, 32'(wdat_s), 0);
        check_val({tag, "_busy"}, 32'(bsy_s), 0);
        check_val({tag, "_done"}, 32'(dn_s), 0);
        check_val({tag, "_phase"}, 32'(ph_s), 0);
        check_val({tag, "_kd"},   32'(kd_s), 0);
        check_val({tag, "_qc"},   32'(qc_s), 0);
        check_val({tag, "_st"},   32'(st_s), 0);
        check_val({tag, "_fsm"},  32'(fsm_s), 0);
    endtask

    task automatic pulse_start(input logic md);
        @(posedge clk); #1;
        start = 1'b1; mode = md;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [10:0] lfsr_step(input logic [10:0] s);
        return {s[9:0], ^(s & 11'h500)};
    endfunction

    task automatic check_phase(input string tag, input int nwords, input int dwid, input logic md,
                               input int ph_exp, input int stall_word, input int stall_len,
                               input int start_at, input int abort_at, output bit aborted);
        logic [10:0] lf;
        logic [10:0] exp;
        logic [10:0] msk;
        bit stalled;
        bit start_high;
        lf = 11'h001;
        msk = 11'((1 << dwid) - 1);
        stalled = 0;
        start_high = 0;
        aborted = 0;
        for (int i = 0; i < nwords; i++) begin
            exp = md ? lf : (11'(i) & msk);
            @(negedge clk);
            if (start_high) begin start = 1'b0; start_high = 0; end
            if (i == start_at) begin start = 1'b1; start_high = 1; end
            if (i == abort_at) begin
                abort = 1'b1;
                #1;
                check_val({tag, "_abort_wenq"}, 32'(wenq_s), 0);
                check_val({tag, "_abort_data"}, 32'(wdat_s), 32'(exp));
                @(posedge clk); #1;
                abort = 1'b0;
                aborted = 1;
                return;
            end
            if (i == stall_word && !stalled) begin
                stalled = 1;
                wfull_n = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    check_val({tag, "_stall_wenq"}, 32'(wenq_s), 0);
                    check_val({tag, "_stall_data"}, 32'(wdat_s), 32'(exp));
                    @(negedge clk);
                end
                wfull_n = 1'b1;
            end
            #1;
            if (i == 0) check_val({tag, "_phase"}, 32'(ph_s), 32'(ph_exp));
            check_val({tag, "_wenq"}, 32'(wenq_s), 1);
            check_val({tag, "_data"}, 32'(wdat_s), 32'(exp));
            lf = lfsr_step(lf);
        end
        if (start_high) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic check_gap(input string tag);
        @(negedge clk); #1;
        check_val({tag, "_wenq"}, 32'(wenq_s), 0);
        check_val({tag, "_busy"}, 32'(bsy_s), 1);
    endtask

    task automatic check_pulse();
        @(negedge clk); #1;
        check_val("pulse_load", 32'(ld_s), 1);
        check_val("pulse_busy", 32'(bsy_s), 1);
        check_val("pulse_wenq", 32'(wenq_s), 0);
        check_val("pulse_kd_clr", 32'(kd_s), 0);
        check_val("pulse_qc_clr", 32'(qc_s), 0);
        check_val("pulse_st_clr", 32'(st_s), 0);
    endtask

    task automatic run_load(input int nw, input int lw, input int qw, input int dwid, input logic md,
                            input int stall_word, input int stall_len, input int start_at,
                            input int abort_at, input int exp_kd, input int exp_qc,
                            input int exp_st, output bit aborted);
        pulse_start(md);
        check_pulse();
        check_phase("nodes", nw, dwid, md, 1, -1, 0, start_at, -1, aborted);
        check_gap("gap_n");
        check_phase("leaves", lw, dwid, md, 2, stall_word, stall_len, -1, -1, aborted);
        check_gap("gap_l");
        check_phase("queries", qw, dwid, md, 3, -1, 0, -1, abort_at, aborted);
        if (aborted) return;
        check_gap("gap_q");
        @(negedge clk); #1;
        check_val("end_done", 32'(dn_s), 1);
        check_val("end_busy", 32'(bsy_s), 0);
        check_val("end_phase", 32'(ph_s), 0);
        check_val("end_kd", 32'(kd_s), 32'(exp_kd));
        check_val("end_qc", 32'(qc_s), 32'(exp_qc));
        check_val("end_st", 32'(st_s), 32'(exp_st));
        // Counters must hold while sitting in DONE.
        repeat (3) @(negedge clk);
        #1;
        check_val("hold_kd", 32'(kd_s), 32'(exp_kd));
        check_val("hold_done", 32'(dn_s), 1);
    endtask

    initial begin
        bit ab;

        // Reset state
        sel = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Small config, ramp, no backpressure (start pulse mid-nodes must be ignored)
        run_load(6, 48, 30, 11, 1'b0, -1, 0, 3, -1, 57, 31, 0, ab);

        // Five-cycle stall at leaf word 10
        run_load(6, 48, 30, 11, 1'b0, 10, 5, -1, -1, 62, 31, 5, ab);

        // Narrow data path: ramp wraps every 16 words
        sel = 1;
        run_load(6, 48, 30, 4, 1'b0, -1, 0, -1, -1, 57, 31, 0, ab);

        // LFSR data, reseeded every phase
        sel = 0;
        run_load(6, 48, 30, 11, 1'b1, -1, 0, -1, -1, 57, 31, 0, ab);

        // Abort at query word 7, then a clean replay
        run_load(6, 48, 30, 11, 1'b0, -1, 0, -1, 7, 57, 31, 0, ab);
        check_val("abort_taken", 32'(ab), 1);
        @(negedge clk); #1;
        check_val("abort_busy", 32'(bsy_s), 0);
        check_val("abort_done", 32'(dn_s), 0);
        check_val("abort_phase", 32'(ph_s), 0);
        check_val("abort_kd_hold", 32'(kd_s), 57);
        check_val("abort_qc_hold", 32'(qc_s), 7);
        run_load(6, 48, 30, 11, 1'b0, -1, 0, -1, -1, 57, 31, 0, ab);

        // Default geometry: reset mid-leaves, then a full run
        sel = 2;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        pulse_start(1'b0);
        check_pulse();
        check_phase("full_nodes", 126, 11, 1'b0, 1, -1, 0, -1, -1, ab);
        check_gap("full_gap_n");
        repeat (40) @(negedge clk);
        #1;
        check_val("mid_leaf_phase", 32'(ph_s), 2);
        check_val("mid_leaf_wenq", 32'(wenq_s), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_load(126, 3072, 2470, 11, 1'b0, -1, 0, -1, -1, 3201, 2471, 0, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
